// File: rtl/move_tick_scheduler.sv
// move_tick_scheduler: cleans the three board buttons and paces the car game
// FSM. Move ticks are released on frame_start every FRAMES_PER_MOVE frames.
// Ticks are suppressed during a collision, and a clean btnC press produces a
// one-cycle restart pulse.

// Per-button cleaner: a 2-FF synchroniser followed by a stability counter.
// The clean level follows the synced level only after the two have differed
// for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle restarts the
// count, so short glitches never reach the clean level.
module mts_btn_clean #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DB_W            = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic clean_o
);

   logic            sync1_q, sync2_q;
   logic            clean_q, clean_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   // Two-stage synchroniser for the asynchronous button level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive disagreeing cycles and flip the clean level on the last one
   always_comb begin
      clean_d = clean_q;
      cnt_d   = '0;
      if (sync2_q != clean_q) begin
         if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            clean_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clean_o = clean_q;

endmodule

module move_tick_scheduler #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DB_W            = 20,
   parameter int FRAMES_PER_MOVE = 4,
   parameter int FR_W            = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnC,
   input  logic       collide,
   output logic       move_tick,
   output logic       move_left,
   output logic       move_right,
   output logic       restart,
   output logic [1:0] sched_state
);

   localparam int NUM_BTN = 3;
   localparam int BTN_L   = 0;
   localparam int BTN_R   = 1;
   localparam int BTN_C   = 2;

   localparam logic [1:0] ST_RUN      = 2'b00;
   localparam logic [1:0] ST_HOLD     = 2'b01;
   localparam logic [1:0] ST_RESTART  = 2'b10;
   localparam logic [1:0] ST_WAIT_REL = 2'b11;

   logic [NUM_BTN-1:0] raw_btn;
   logic [NUM_BTN-1:0] clean_btn;

   assign raw_btn = {btnC, btnR, btnL};

   // One cleaner per button, all identical
   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      mts_btn_clean #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .DB_W            (DB_W)
      ) u_clean (
         .clk     (clk),
         .rst     (rst),
         .raw_i   (raw_btn[b]),
         .clean_o (clean_btn[b])
      );
   end

   logic c_prev_q;
   logic c_rise;

   // Previous clean btnC level, used to find its rising edge
   always_ff @(posedge clk) begin
      if (rst) c_prev_q <= 1'b0;
      else     c_prev_q <= clean_btn[BTN_C];
   end

   assign c_rise = clean_btn[BTN_C] & ~c_prev_q;

   logic [1:0]      state_q, state_d;
   logic [FR_W-1:0] fcnt_q, fcnt_d;
   logic            tick_q, tick_d;
   logic            left_q, left_d;
   logic            right_q, right_d;

   // Scheduler next state. Collide outranks a btnC edge, which outranks frame_start
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      tick_d  = 1'b0;
      left_d  = 1'b0;
      right_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (collide) begin
               state_d = ST_HOLD;
               fcnt_d  = '0;
            end else if (c_rise) begin
               state_d = ST_RESTART;
            end else if (frame_start) begin
               if (fcnt_q == FR_W'(FRAMES_PER_MOVE - 1)) begin
                  tick_d  = 1'b1;
                  // Pressing both buttons cancels the step; the FSM idles on the tick
                  left_d  = clean_btn[BTN_L] & ~clean_btn[BTN_R];
                  right_d = clean_btn[BTN_R] & ~clean_btn[BTN_L];
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FR_W'(1);
               end
            end
         end
         ST_HOLD: begin
            fcnt_d = '0;
            if (c_rise) state_d = ST_RESTART;
         end
         ST_RESTART: begin
            fcnt_d  = '0;
            state_d = ST_WAIT_REL;
         end
         ST_WAIT_REL: begin
            fcnt_d = '0;
            if (!clean_btn[BTN_C]) state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
            fcnt_d  = '0;
         end
      endcase
   end

   // Scheduler state and registered tick outputs. Reset drops any pending pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
         tick_q  <= 1'b0;
         left_q  <= 1'b0;
         right_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         tick_q  <= tick_d;
         left_q  <= left_d;
         right_q <= right_d;
      end
   end

   assign move_tick   = tick_q;
   assign move_left   = left_q;
   assign move_right  = right_q;
   assign restart     = (state_q == ST_RESTART);
   assign sched_state = state_q;

endmodule

// File: tb/tb_move_tick_scheduler.sv
// Randomised and directed bench for move_tick_scheduler. A cycle-level
// behavioural model predicts every output, and a compare process checks them
// on each falling edge.
module tb_move_tick_scheduler;

   localparam int D = 4;
   localparam int F = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic       btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
   logic       collide = 1'b0;
   logic       move_tick, move_left, move_right, restart;
   logic [1:0] sched_state;

   move_tick_scheduler #(
      .DEBOUNCE_CYCLES (D),
      .DB_W            (3),
      .FRAMES_PER_MOVE (F),
      .FR_W            (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .btnL        (btnL),
      .btnR        (btnR),
      .btnC        (btnC),
      .collide     (collide),
      .move_tick   (move_tick),
      .move_left   (move_left),
      .move_right  (move_right),
      .restart     (restart),
      .sched_state (sched_state)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nmis = 0;

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // raw1/raw2: button levels seen one and two edges ago.
   // A clean level flips once D successive synced samples disagree with it.
   bit   m_ok = 0;
   bit   raw1 [3], raw2 [3];
   bit   m_clean [3];
   int   streak [3];
   bit   m_cprev;
   int   m_state;
   int   m_frames;
   bit   e_tick, e_left, e_right;
   bit   rise, syn;
   bit   cur_raw [3];

   always @(posedge clk) begin
      cur_raw[0] = btnL; cur_raw[1] = btnR; cur_raw[2] = btnC;
      e_tick = 0; e_left = 0; e_right = 0;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            raw1[b] = 0; raw2[b] = 0; m_clean[b] = 0; streak[b] = 0;
         end
         m_cprev = 0; m_state = 0; m_frames = 0; m_ok = 1;
      end else begin
         rise = m_clean[2] && !m_cprev;
         if (m_state == 0) begin
            if (collide) begin
               m_state = 1; m_frames = 0;
            end else if (rise) begin
               m_state = 2;
            end else if (frame_start) begin
               m_frames = m_frames + 1;
               if (m_frames == F) begin
                  m_frames = 0;
                  e_tick   = 1;
                  e_left   = m_clean[0] && !m_clean[1];
                  e_right  = m_clean[1] && !m_clean[0];
               end
            end
         end else if (m_state == 1) begin
            if (rise) m_state = 2;
         end else if (m_state == 2) begin
            m_state = 3; m_frames = 0;
         end else begin
            if (!m_clean[2]) m_state = 0;
         end
         m_cprev = m_clean[2];
         for (int b = 0; b < 3; b++) begin
            syn = raw2[b];
            if (syn != m_clean[b]) begin
               streak[b] = streak[b] + 1;
               if (streak[b] == D) begin
                  m_clean[b] = syn; streak[b] = 0;
               end
            end else begin
               streak[b] = 0;
            end
            raw2[b] = raw1[b];
            raw1[b] = cur_raw[b];
         end
      end
   end

   // ---------------- compare process ----------------
   int n_tick = 0, n_left = 0, n_right = 0, n_restart = 0;

   always @(negedge clk) begin
      if (m_ok) begin
         chk("move_tick",   int'(move_tick),   int'(e_tick));
         chk("move_left",   int'(move_left),   int'(e_left));
         chk("move_right",  int'(move_right),  int'(e_right));
         chk("restart",     int'(restart),     int'(m_state == 2));
         chk("sched_state", int'(sched_state), m_state);
         if (move_tick)  n_tick++;
         if (move_left)  n_left++;
         if (move_right) n_right++;
         if (restart)    n_restart++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input int gap);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      idle(gap - 1);
   endtask

   // Press btnC while in HOLD, drop collide, then release back to RUN
   task automatic recover();
      btnC = 1'b1; idle(3);
      collide = 1'b0; idle(7);
      btnC = 1'b0; idle(10);
   endtask

   int t0, l0, r0, c0;

   initial begin
      idle(3);
      chk("reset_tick", int'(move_tick), 0);
      chk("reset_state", int'(sched_state), 0);
      rst = 1'b0;
      idle(2);

      // Hold right: six frames make two right ticks
      btnR = 1'b1; idle(10);
      t0 = n_tick; l0 = n_left; r0 = n_right;
      repeat (6) frame(20);
      chk("s1_ticks", n_tick - t0, 2);
      chk("s1_right", n_right - r0, 2);
      chk("s1_left",  n_left - l0, 0);
      btnR = 1'b0; idle(10);

      // Short left glitch never becomes a clean press
      btnL = 1'b1; idle(3);
      btnL = 1'b0; idle(10);
      t0 = n_tick; l0 = n_left;
      repeat (3) frame(5);
      chk("s2_ticks", n_tick - t0, 1);
      chk("s2_left",  n_left - l0, 0);

      // Collision hold, restart and release
      collide = 1'b1; idle(2);
      t0 = n_tick;
      repeat (5) frame(5);
      chk("s3_hold_ticks", n_tick - t0, 0);
      chk("s3_hold_state", int'(sched_state), 1);
      c0 = n_restart;
      btnC = 1'b1; idle(3);
      collide = 1'b0; idle(7);
      chk("s3_restart_cnt", n_restart - c0, 1);
      chk("s3_wait_state", int'(sched_state), 3);
      btnC = 1'b0; idle(10);
      chk("s3_run_state", int'(sched_state), 0);
      t0 = n_tick;
      repeat (2) frame(5);
      chk("s3_early_ticks", n_tick - t0, 0);
      frame(5);
      chk("s3_ticks", n_tick - t0, 1);

      // frame_start coincident with collide at count 2
      repeat (2) frame(5);
      t0 = n_tick;
      frame_start = 1'b1; collide = 1'b1;
      @(negedge clk);
      frame_start = 1'b0; idle(3);
      chk("s4_ticks", n_tick - t0, 0);
      chk("s4_state", int'(sched_state), 1);
      recover();

      // Both directions held: tick with no direction
      btnL = 1'b1; btnR = 1'b1; idle(10);
      t0 = n_tick; l0 = n_left; r0 = n_right;
      repeat (3) frame(5);
      chk("s5_ticks", n_tick - t0, 1);
      chk("s5_left",  n_left - l0, 0);
      chk("s5_right", n_right - r0, 0);
      btnL = 1'b0; btnR = 1'b0; idle(10);

      // Reset on the edge that would register a tick
      repeat (2) frame(5);
      t0 = n_tick;
      frame_start = 1'b1; rst = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("s6_tick", int'(move_tick), 0);
      chk("s6_state", int'(sched_state), 0);
      rst = 1'b0; idle(3);
      chk("s6_ticks", n_tick - t0, 0);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         frame_start = ($urandom % 6) == 0;
         if (($urandom % 40) == 0) btnL = ~btnL;
         if (($urandom % 40) == 0) btnR = ~btnR;
         if (($urandom % 60) == 0) btnC = ~btnC;
         if (($urandom % 150) == 0) collide = ~collide;
         rst = ($urandom % 900) == 0;
         @(negedge clk);
      end
      rst = 1'b0; frame_start = 1'b0;
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
